// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and transmitter.
//   DEFAULT_CLKS_PER_BIT : clocks per bit at 100 MHz / 9600 baud
//   FRAME_BITS           : start + 8 data + parity + stop
//   uart_state_t         : receiver FSM state encoding
//   parity_even()        : parity bit the transmitter appends (XOR of data)
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int FRAME_BITS           = 11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic parity_even(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
//   clk_top  : clock
//   rst_top  : synchronous active-high reset, both flops reset to 1 (idle line)
//   in_async : raw serial input
//   out_sync : synchronized serial line
module uart_rx_sync (
    input  logic clk_top,
    input  logic rst_top,
    input  logic in_async,
    output logic out_sync
);

    logic meta;

    always_ff @(posedge clk_top) begin
        if (rst_top) begin
            meta     <= 1'b1;
            out_sync <= 1'b1;
        end else begin
            meta     <= in_async;
            out_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8E1 UART receiver (start, 8 data LSB first, even parity, stop).
//   clk_top    : clock
//   rst_top    : synchronous active-high reset
//   in_rx      : asynchronous serial line, idles high
//   data_out   : last received byte, held until the next completed frame
//   data_valid : one-cycle pulse per completed frame (good or bad)
//   parity_err : parity mismatch of the last frame
//   frame_err  : stop bit of the last frame read 0
//   busy       : high from start-bit detection until the frame ends/aborts
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_top,
    input  logic       rst_top,
    input  logic       in_rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // The start sample lands half a bit after t0; the counter reads
    // HALF-1 on that edge because it starts at 0 on the cycle after t0.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bit;
    logic             rx_sync;
    logic             rx_prev;
    logic             dv_pend;

    uart_rx_sync u_sync (
        .clk_top  (clk_top),
        .rst_top  (rst_top),
        .in_async (in_rx),
        .out_sync (rx_sync)
    );

    always_ff @(posedge clk_top) begin
        if (rst_top) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            rx_prev    <= 1'b1;
            dv_pend    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_prev    <= rx_sync;
            dv_pend    <= 1'b0;
            // Results land on the stop sample; the strobe follows a cycle later.
            data_valid <= dv_pend;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            // Line back high mid start bit: treat as a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= PARITY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_sync;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        data_out   <= shreg;
                        parity_err <= par_bit ^ parity_even(shreg);
                        frame_err  <= ~rx_sync;
                        dv_pend    <= 1'b1;
                        if (rx_sync) begin
                            // Back to IDLE mid stop bit so a start edge right
                            // after it is caught.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // Break / low line: do not rearm until it returns high.
                    if (rx_sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk_top cycles per bit (100 MHz, 9600 baud).
REQ-002 SHALL have port clk_top, input, 1, single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_top, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_rx, input, 1, asynchronous serial line; idles high.
REQ-005 SHALL have port data_out, output, 8, last received data byte.
REQ-006 SHALL have port data_valid, output, 1, one-cycle pulse when a frame completes.
REQ-007 SHALL have port parity_err, output, 1, parity status of the last frame; valid with data_valid.
REQ-008 SHALL have port frame_err, output, 1, stop-bit status of the last frame; valid with data_valid.
REQ-009 SHALL have port busy, output, 1, high from start-bit detection until the frame ends or is aborted.

Function
REQ-010 SHALL accept an 11-bit frame: start 0; data[0]..data[7] LSB first; parity; stop 1.
REQ-011 SHALL use even parity: the parity bit equals the XOR of the 8 data bits, matching the team's transmitter.
REQ-012 SHALL pass in_rx through a 2-flop synchronizer before any use.
REQ-013 SHALL use the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE, with IDLE out of reset.
REQ-014 SHALL move IDLE->START on a synchronized high-to-low edge; the cycle the edge is seen is t0.
REQ-015 SHALL use a baud counter that wraps at CLKS_PER_BIT-1.
REQ-016 SHALL sample start, data, parity and stop at mid-bit, at t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT for k = 0..10, where CLKS_PER_BIT/2 uses integer division.
REQ-017 SHALL move START->IDLE with no data_valid if the start sample is 1 (glitch rejection); otherwise START->DATA.
REQ-018 SHALL shift in 8 data samples in DATA using a 3-bit bit index, then move to PARITY, then to STOP.
REQ-019 SHALL, at the stop sample: update data_out, parity_err and frame_err; pulse data_valid on the next cycle.
REQ-020 SHALL set parity_err = 1 when the received parity differs from the XOR of the received data.
REQ-021 SHALL set frame_err = 1 when the stop sample is 0.
REQ-022 SHALL pulse data_valid on every completed frame, including erroneous ones.
REQ-023 SHALL hold data_out, parity_err and frame_err stable until the next completed frame.
REQ-024 SHALL go STOP->IDLE on a good stop bit, so a start edge in the same stop bit period is accepted (back-to-back frames).
REQ-025 SHALL go STOP->WAIT_IDLE when the stop sample is 0, and leave WAIT_IDLE only after the synchronized line reads 1 (break handling).
REQ-026 SHALL drive busy = 1 in START, DATA, PARITY, STOP and WAIT_IDLE, and 0 in IDLE.
REQ-027 SHALL have a latency of 2 synchronizer cycles + 10.5 bit times + 1 cycle from the line falling edge to data_valid.

Reset
REQ-028 SHALL, while rst_top = 1 at a clock edge: state = IDLE; counters = 0; data_out = 0x00; data_valid, parity_err, frame_err and busy = 0; synchronizer flops = 1.
REQ-029 SHALL, when rst_top is asserted mid-frame, abort the frame with no data_valid, and accept a fresh frame once rst_top is released.

Structure
REQ-030 SHALL place the following in shared package uart_pkg: default CLKS_PER_BIT, FRAME_BITS = 11, state encoding, and a parity function reused by the transmitter.
REQ-031 SHALL implement the synchronizer as sub-module uart_rx_sync; all other logic stays in uart_rx.

Verification (CLKS_PER_BIT = 16 in simulation)
REQ-032 SHALL cover: send 0xA5 with parity 0 and stop 1 -> data_out = 0xA5, data_valid high exactly 1 cycle, parity_err = 0, frame_err = 0.
REQ-033 SHALL cover: send 0x01 with parity bit 0 -> data_out = 0x01, parity_err = 1, frame_err = 0.
REQ-034 SHALL cover: send 0x3C with stop 0, then hold in_rx low 40 cycles -> frame_err = 1, one data_valid only, busy stays high until the line goes high.
REQ-035 SHALL cover: a 3-cycle low glitch on an idle line -> no data_valid, busy back to 0 within 12 cycles.
REQ-036 SHALL cover: 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses 176 cycles apart, both error-free.
REQ-037 SHALL cover: rst_top asserted 1 cycle during data bit 4 -> all outputs 0 the next cycle; a following 0x5A frame is received correctly.
